// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// mem_stage: memory-access pipeline stage. Passes non-memory ALU results
// straight to a one-entry writeback register, and runs LW/SW through a
// request/acknowledge handshake that is aborted after TIMEOUT cycles.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  opcode,
  input  logic [15:0] alu_out,
  input  logic [15:0] store_data,
  input  logic [3:0]  dst_reg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] wb_data,
  output logic [3:0]  wb_reg,
  output logic        wb_en,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  // Register-file write enable implied by an opcode (stores, branches and
  // the remaining no-result opcodes do not write back).
  function automatic logic wb_en_of(input logic [3:0] op);
    logic en;
    case (op)
      4'b1001, 4'b1100, 4'b1101, 4'b1111: en = 1'b0;
      default:                            en = 1'b1;
    endcase
    return en;
  endfunction

  // LW and SW are the only opcodes that touch memory.
  function automatic logic is_mem_of(input logic [3:0] op);
    logic m;
    case (op)
      4'b1000, 4'b1001: m = 1'b1;
      default:          m = 1'b0;
    endcase
    return m;
  endfunction

  state_t         state_r, state_nxt;
  logic [CW-1:0]  cnt_r, cnt_nxt;
  logic [3:0]     dst_r;
  logic           out_valid_r;
  logic [15:0]    wb_data_r;
  logic [3:0]     wb_reg_r;
  logic           wb_en_r;
  logic           bus_err_r;
  logic           mem_we_r;
  logic [15:0]    mem_addr_r;
  logic [15:0]    mem_wdata_r;

  logic           accept_s;
  logic           drain_s;
  logic           start_s;
  logic           load_s;
  logic           timeout_s;
  logic [15:0]    ld_data_s;
  logic [3:0]     ld_reg_s;
  logic           ld_en_s;

  assign in_ready  = !rst && (state_r == ST_IDLE) && (!out_valid_r || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign drain_s   = out_valid_r && out_ready;

  assign mem_req   = (state_r == ST_REQ);
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign out_valid = out_valid_r;
  assign wb_data   = wb_data_r;
  assign wb_reg    = wb_reg_r;
  assign wb_en     = wb_en_r;
  assign bus_err   = bus_err_r;

  // Next-state, wait counter and output-register load selection.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    start_s   = 1'b0;
    load_s    = 1'b0;
    timeout_s = 1'b0;
    ld_data_s = 16'h0000;
    ld_reg_s  = 4'h0;
    ld_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_mem_of(opcode)) begin
          state_nxt = ST_REQ;
          cnt_nxt   = '0;
          start_s   = 1'b1;
        end else if (accept_s) begin
          load_s    = 1'b1;
          ld_data_s = alu_out;
          ld_reg_s  = dst_reg;
          ld_en_s   = wb_en_of(opcode);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          // Ack wins even on the final wait cycle.
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          load_s    = 1'b1;
          ld_data_s = mem_we_r ? 16'h0000 : mem_rdata;
          ld_reg_s  = dst_r;
          ld_en_s   = !mem_we_r;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          load_s    = 1'b1;
          timeout_s = 1'b1;
          ld_data_s = 16'hFFFF;
          ld_reg_s  = dst_r;
          ld_en_s   = 1'b0;
        end else begin
          cnt_nxt   = cnt_r + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

  // Memory request fields, latched at acceptance and held through REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 16'h0000;
      mem_wdata_r <= 16'h0000;
      dst_r       <= 4'h0;
    end else if (start_s) begin
      mem_we_r    <= (opcode == 4'b1001);
      mem_addr_r  <= alu_out & 16'hFFFE;
      mem_wdata_r <= store_data;
      dst_r       <= dst_reg;
    end else begin
      mem_we_r    <= mem_we_r;
      mem_addr_r  <= mem_addr_r;
      mem_wdata_r <= mem_wdata_r;
      dst_r       <= dst_r;
    end
  end

  // One-entry writeback register; a load the same edge as a drain keeps it full.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      wb_data_r   <= 16'h0000;
      wb_reg_r    <= 4'h0;
      wb_en_r     <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      wb_data_r   <= ld_data_s;
      wb_reg_r    <= ld_reg_s;
      wb_en_r     <= ld_en_s;
    end else if (drain_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Sticky bus-error flag, set by a timed-out access.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err_r <= 1'b0;
    end else if (timeout_s) begin
      bus_err_r <= 1'b1;
    end else begin
      bus_err_r <= bus_err_r;
    end
  end

endmodule
